// File: rtl/conv_window_gen.sv
// 3x3 sliding window over three aligned row taps, with column/row tracking for valid/row/frame flags.
// Latency: window and flags are registered, 1 cycle after the newest column is accepted; en=0 stalls all state.
module conv_window_gen #(
    parameter int DATA_W = 8,
    parameter int COL_W  = 9,
    parameter int ROW_W  = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [COL_W-1:0]    col,
    input  logic [ROW_W-1:0]    row,
    input  logic [DATA_W-1:0]   in_top,
    input  logic [DATA_W-1:0]   in_mid,
    input  logic [DATA_W-1:0]   in_bot,
    output logic [9*DATA_W-1:0] win,
    output logic                win_valid,
    output logic                row_end,
    output logic                frame_end
);

    logic [9*DATA_W-1:0] win_q, win_d;
    logic [COL_W-1:0]    col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
    logic                win_valid_q, win_valid_d;
    logic                row_end_q, row_end_d;
    logic                frame_end_q, frame_end_d;
    logic                last_col, last_row;

    always_comb begin
        last_col    = (col_cnt_q == col - COL_W'(1));
        last_row    = (row_cnt_q == row - ROW_W'(1));
        win_d       = win_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        // Flags use the pre-increment position of the pixel being accepted.
        win_valid_d = en && (col_cnt_q >= COL_W'(2)) && (row_cnt_q >= ROW_W'(2));
        row_end_d   = en && last_col;
        frame_end_d = en && last_col && last_row;
        if (en) begin
            for (int r = 0; r < 3; r++) begin
                win_d[DATA_W*(3*r)   +: DATA_W] = win_q[DATA_W*(3*r+1) +: DATA_W];
                win_d[DATA_W*(3*r+1) +: DATA_W] = win_q[DATA_W*(3*r+2) +: DATA_W];
            end
            win_d[DATA_W*2 +: DATA_W] = in_top;
            win_d[DATA_W*5 +: DATA_W] = in_mid;
            win_d[DATA_W*8 +: DATA_W] = in_bot;
            if (last_col) begin
                col_cnt_d = '0;
                row_cnt_d = last_row ? '0 : row_cnt_q + ROW_W'(1);
            end else begin
                col_cnt_d = col_cnt_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q       <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            win_valid_q <= 1'b0;
            row_end_q   <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            win_q       <= win_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            win_valid_q <= win_valid_d;
            row_end_q   <= row_end_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign win       = win_q;
    assign win_valid = win_valid_q;
    assign row_end   = row_end_q;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: reset, full frame, row wrap, stall, narrow rows, back-to-back frames.
module tb_conv_window_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [8:0]  col;
    logic [8:0]  row;
    logic [7:0]  in_top, in_mid, in_bot;
    logic [71:0] win;
    logic        win_valid, row_end, frame_end;

    int n_cmp = 0;
    int n_bad = 0;

    conv_window_gen #(.DATA_W(8), .COL_W(9), .ROW_W(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .col       (col),
        .row       (row),
        .in_top    (in_top),
        .in_mid    (in_mid),
        .in_bot    (in_bot),
        .win       (win),
        .win_valid (win_valid),
        .row_end   (row_end),
        .frame_end (frame_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        int first_v;
        int nv;
        rst_n = 1'b0; en = 1'b0; col = '0; row = '0;
        in_top = '0; in_mid = '0; in_bot = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (win !== 72'd0) begin n_bad++; $display("FAIL rst_win got=%h exp=0", win); end
        n_cmp++; if (win_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", win_valid); end
        n_cmp++; if (row_end !== 1'b0) begin n_bad++; $display("FAIL rst_row_end got=%b exp=0", row_end); end
        n_cmp++; if (frame_end !== 1'b0) begin n_bad++; $display("FAIL rst_frame_end got=%b exp=0", frame_end); end
        rst_n = 1'b1;
        col = 9'd8; row = 9'd4;
        for (int p = 0; p < 10; p++) begin
            en = 1'b1; in_top = 8'(p % 8 + 1); in_mid = 8'(p % 8 + 1); in_bot = 8'(p % 8 + 1);
            @(posedge clk); #1;
        end
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (win !== 72'd0) begin n_bad++; $display("FAIL midrst_win got=%h exp=0", win); end
        n_cmp++; if (win_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got=%b exp=0", win_valid); end
        n_cmp++; if (row_end !== 1'b0) begin n_bad++; $display("FAIL midrst_row_end got=%b exp=0", row_end); end
        n_cmp++; if (frame_end !== 1'b0) begin n_bad++; $display("FAIL midrst_frame_end got=%b exp=0", frame_end); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (win !== 72'd0 || win_valid !== 1'b0) begin
                n_bad++; $display("FAIL midrst_hold cyc=%0d win=%h valid=%b exp=0/0", i, win, win_valid);
            end
        end
        rst_n = 1'b1;
        first_v = -1; nv = 0;
        for (int p = 0; p < 32; p++) begin
            en = 1'b1; in_top = 8'(p % 8); in_mid = 8'(p % 8); in_bot = 8'(p % 8);
            @(posedge clk); #1;
            if (win_valid === 1'b1) begin
                nv++;
                if (first_v < 0) first_v = p;
            end
        end
        en = 1'b0;
        n_cmp++; if (first_v !== 18) begin n_bad++; $display("FAIL restart_first_valid got=%0d exp=18", first_v); end
        n_cmp++; if (nv !== 12) begin n_bad++; $display("FAIL restart_valid_count got=%0d exp=12", nv); end
    endtask

    task automatic test_full_frame();
        int nv, nr, nf;
        logic [71:0] exp_w;
        nv = 0; nr = 0; nf = 0;
        col = 9'd8; row = 9'd4;
        for (int p = 0; p < 32; p++) begin
            int k;
            int r;
            k = p % 8; r = p / 8;
            en = 1'b1; in_top = 8'(k); in_mid = 8'(k); in_bot = 8'(k);
            @(posedge clk); #1;
            n_cmp++; if (win_valid !== (k >= 2 && r >= 2)) begin
                n_bad++; $display("FAIL ff_valid p=%0d got=%b exp=%b", p, win_valid, (k >= 2 && r >= 2));
            end
            n_cmp++; if (row_end !== (k == 7)) begin
                n_bad++; $display("FAIL ff_row_end p=%0d got=%b exp=%b", p, row_end, (k == 7));
            end
            n_cmp++; if (frame_end !== (p == 31)) begin
                n_bad++; $display("FAIL ff_frame_end p=%0d got=%b exp=%b", p, frame_end, (p == 31));
            end
            if (win_valid === 1'b1) begin
                nv++;
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        exp_w[8*(3*rr+cc) +: 8] = 8'(k - 2 + cc);
                n_cmp++; if (win !== exp_w) begin
                    n_bad++; $display("FAIL ff_win p=%0d got=%h exp=%h", p, win, exp_w);
                end
            end
            if (row_end === 1'b1) nr++;
            if (frame_end === 1'b1) nf++;
        end
        en = 1'b0;
        n_cmp++; if (nv !== 12) begin n_bad++; $display("FAIL ff_valid_count got=%0d exp=12", nv); end
        n_cmp++; if (nr !== 4) begin n_bad++; $display("FAIL ff_row_end_count got=%0d exp=4", nr); end
        n_cmp++; if (nf !== 1) begin n_bad++; $display("FAIL ff_frame_end_count got=%0d exp=1", nf); end
    endtask

    task automatic test_row_wrap();
        col = 9'd8; row = 9'd4;
        for (int p = 0; p < 32; p++) begin
            int k;
            int r;
            k = p % 8; r = p / 8;
            en = 1'b1; in_top = 8'(k); in_mid = 8'(k); in_bot = 8'(k);
            @(posedge clk); #1;
            if (r >= 2 && k < 2) begin
                n_cmp++; if (win_valid !== 1'b0) begin
                    n_bad++; $display("FAIL wrap_valid r=%0d c=%0d got=%b exp=0", r, k, win_valid);
                end
                n_cmp++; if (win === 72'd0) begin
                    n_bad++; $display("FAIL wrap_win_nonzero r=%0d c=%0d got=%h exp=nonzero", r, k, win);
                end
            end
            if (r >= 2 && k == 2) begin
                n_cmp++; if (win_valid !== 1'b1) begin
                    n_bad++; $display("FAIL wrap_reassert r=%0d got=%b exp=1", r, win_valid);
                end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_stall();
        int nv, nr, nf, p, cyc;
        logic [71:0] prev_w, exp_w;
        nv = 0; nr = 0; nf = 0; p = 0; cyc = 0;
        col = 9'd8; row = 9'd4;
        while (p < 32 && cyc < 200) begin
            int k;
            int r;
            k = p % 8; r = p / 8;
            prev_w = win;
            if (cyc % 4 == 0 || cyc % 4 == 3) begin
                en = 1'b1; in_top = 8'(k); in_mid = 8'(k); in_bot = 8'(k);
                @(posedge clk); #1;
                n_cmp++; if (win_valid !== (k >= 2 && r >= 2)) begin
                    n_bad++; $display("FAIL st_valid p=%0d got=%b exp=%b", p, win_valid, (k >= 2 && r >= 2));
                end
                if (win_valid === 1'b1) begin
                    nv++;
                    for (int rr = 0; rr < 3; rr++)
                        for (int cc = 0; cc < 3; cc++)
                            exp_w[8*(3*rr+cc) +: 8] = 8'(k - 2 + cc);
                    n_cmp++; if (win !== exp_w) begin
                        n_bad++; $display("FAIL st_win p=%0d got=%h exp=%h", p, win, exp_w);
                    end
                end
                if (row_end === 1'b1) nr++;
                if (frame_end === 1'b1) nf++;
                p++;
            end else begin
                en = 1'b0; in_top = 8'($urandom); in_mid = 8'($urandom); in_bot = 8'($urandom);
                @(posedge clk); #1;
                n_cmp++; if (win !== prev_w) begin
                    n_bad++; $display("FAIL st_hold cyc=%0d got=%h exp=%h", cyc, win, prev_w);
                end
                n_cmp++; if ({win_valid, row_end, frame_end} !== 3'b000) begin
                    n_bad++; $display("FAIL st_flags cyc=%0d got=%b exp=000", cyc, {win_valid, row_end, frame_end});
                end
            end
            cyc++;
        end
        en = 1'b0;
        n_cmp++; if (p !== 32) begin n_bad++; $display("FAIL st_budget pixels=%0d exp=32", p); end
        n_cmp++; if (nv !== 12) begin n_bad++; $display("FAIL st_valid_count got=%0d exp=12", nv); end
        n_cmp++; if (nr !== 4) begin n_bad++; $display("FAIL st_row_end_count got=%0d exp=4", nr); end
        n_cmp++; if (nf !== 1) begin n_bad++; $display("FAIL st_frame_end_count got=%0d exp=1", nf); end
    endtask

    task automatic test_degenerate();
        int nv, nr, nf;
        nv = 0; nr = 0; nf = 0;
        col = 9'd2; row = 9'd4;
        for (int p = 0; p < 8; p++) begin
            en = 1'b1; in_top = 8'(p + 1); in_mid = 8'(p + 2); in_bot = 8'(p + 3);
            @(posedge clk); #1;
            if (win_valid === 1'b1) nv++;
            if (row_end === 1'b1) nr++;
            if (frame_end === 1'b1) begin
                nf++;
                n_cmp++; if (p !== 7) begin n_bad++; $display("FAIL dg_frame_end_pos got=%0d exp=7", p); end
            end
        end
        en = 1'b0;
        n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL dg_valid_count got=%0d exp=0", nv); end
        n_cmp++; if (nr !== 4) begin n_bad++; $display("FAIL dg_row_end_count got=%0d exp=4", nr); end
        n_cmp++; if (nf !== 1) begin n_bad++; $display("FAIL dg_frame_end_count got=%0d exp=1", nf); end
    endtask

    task automatic test_back_to_back();
        int nv;
        logic [71:0] exp_w;
        nv = 0;
        exp_w = 72'h32_31_30_22_21_20_12_11_10;
        col = 9'd3; row = 9'd3;
        for (int p = 0; p < 18; p++) begin
            int k;
            k = p % 3;
            en = 1'b1; in_top = 8'(8'h10 + k); in_mid = 8'(8'h20 + k); in_bot = 8'(8'h30 + k);
            @(posedge clk); #1;
            n_cmp++; if (win_valid !== (p == 8 || p == 17)) begin
                n_bad++; $display("FAIL b2b_valid p=%0d got=%b exp=%b", p, win_valid, (p == 8 || p == 17));
            end
            n_cmp++; if (frame_end !== (p == 8 || p == 17)) begin
                n_bad++; $display("FAIL b2b_frame_end p=%0d got=%b exp=%b", p, frame_end, (p == 8 || p == 17));
            end
            if (win_valid === 1'b1) begin
                nv++;
                n_cmp++; if (win !== exp_w) begin
                    n_bad++; $display("FAIL b2b_win p=%0d got=%h exp=%h", p, win, exp_w);
                end
            end
        end
        en = 1'b0;
        n_cmp++; if (nv !== 2) begin n_bad++; $display("FAIL b2b_valid_count got=%0d exp=2", nv); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_row_wrap();
        test_stall();
        test_degenerate();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Downstream stage of the register-array line-buffer stack in CCM.
- Consumes the three vertically aligned row taps the stack produces: top (two rows back), mid (one row back) and bot (current row).
- Assembles a 3x3 sliding convolution window and flags which windows are valid.
- Tracks column and row position so that windows straddling a row wrap, or lying in the first two rows of a frame, are suppressed.

Parameters:
DATA_W, 8, pixel width in bits (matches the stack's 8-bit buf_out)
COL_W, 9, width of the column-count input and column counter
ROW_W, 9, width of the row-count input and row counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  one pixel column presented this cycle; all state holds when low
col  input  COL_W  row length in pixels; sampled every accepted cycle
row  input  ROW_W  frame height in rows; sampled every accepted cycle
in_top  input  DATA_W  pixel from the row two lines above
in_mid  input  DATA_W  pixel from the row one line above
in_bot  input  DATA_W  pixel from the current row
win  output  9*DATA_W  3x3 window; element (r,c) at bits [DATA_W*(3r+c) +: DATA_W]
win_valid  output  1  win holds a legal window this cycle
row_end  output  1  one-cycle pulse: last column of a row accepted
frame_end  output  1  one-cycle pulse: last column of the last row accepted

Behaviour:
- Reset (async, rst_n=0): all window registers, col_cnt, row_cnt, win_valid, row_end and frame_end go to 0. Reset mid-frame discards all partial state; the next accepted pixel is treated as (row 0, col 0).
- Window register array:
  - 3 rows x 3 columns; r=0 top, r=1 mid, r=2 bot; c=0 oldest/leftmost, c=2 newest.
  - On an en cycle, each row shifts c0<-c1<-c2, and c2 loads in_top, in_mid or in_bot respectively.
  - win is the direct register contents, so the window appears 1 cycle after its newest column is accepted.
- Counters (advance only when en=1):
  - col_cnt increments; when col_cnt==col-1 it wraps to 0 and row_cnt increments.
  - When row_cnt==row-1 and col_cnt==col-1, both wrap to 0 (new frame).
- Registered flags, updated every cycle:
  - win_valid <= en && col_cnt>=2 && row_cnt>=2, evaluated on the pre-increment counts of the accepted pixel.
  - row_end <= en && col_cnt==col-1.
  - frame_end <= en && col_cnt==col-1 && row_cnt==row-1.
  - All three are 0 in any cycle following an en=0 cycle.
- Row wrap: at col_cnt 0 and 1 of each row the window still holds columns from the previous row. win_valid is therefore 0 for those two positions. The shift registers are not flushed at a wrap.
- Degenerate sizes:
  - col<3 or row<3: win_valid never asserts; row_end and frame_end still pulse per the rules above.
  - col==0 or row==0: illegal; behaviour undefined and not checked.
- Counts per frame: exactly (col-2)*(row-2) win_valid pulses, row row_end pulses, and 1 frame_end pulse.
- Back-to-back frames need no idle cycle. Pixel (0,0) of frame N+1 may follow frame_end's source pixel directly.
- No arithmetic widening. Comparisons are unsigned at COL_W/ROW_W width. Pixel data is passed through unmodified.

Test Plan:
- Reset mid-stream:
  - Stimulus: col=8, row=4; drive 10 pixels; pulse rst_n low for 3 cycles; restart.
  - Required: win, win_valid, row_end and frame_end read 0 during reset; the first valid window after restart appears only at row 2, col 2.
- Full frame:
  - Stimulus: col=8, row=4, en held high; in_top=in_mid=in_bot=col_index.
  - Required: 12 win_valid pulses, 4 row_end pulses, 1 frame_end pulse on the cycle after the 32nd pixel.
  - Required: on every win_valid, win c0/c1/c2 = k-2/k-1/k across all rows, where k is the column of the newest pixel.
- Row-wrap suppression:
  - Stimulus: col=8, row=4; rows 2 and 3.
  - Required: win_valid is 0 on the cycles after col 0 and col 1 of each row, even though win is nonzero; it reasserts after col 2.
- Stall:
  - Stimulus: same frame as the full-frame case, with en toggled 1,0,0,1 repeatedly.
  - Required: identical sequence of valid windows and pulse counts; win unchanged across the en=0 cycles; win_valid is 0 in those cycles.
- Degenerate width:
  - Stimulus: col=2, row=4, 8 pixels.
  - Required: win_valid never 1; row_end pulses 4 times; frame_end pulses once.
- Back-to-back frames:
  - Stimulus: col=3, row=3, 18 pixels contiguous.
  - Required: win_valid exactly twice, on the cycle after pixel 9 and after pixel 18; frame_end coincides with both.
